alu_seq_bcd: RTL and testbench

ALU_SEQ_BCD -- requirements
Module: alu_seq_bcd

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_bin2bcd.sv | 63 ++++++
 rtl/alu_seq_bcd.sv | 184 ++++++++++++++++++
 tb/tb_alu_seq_bcd.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU with BCD / seven-segment output:
// operation modes, controller states and the decimal digit segment patterns.
package alu_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_MUL = 2'b10,
        MODE_NEG = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_CONV = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Active-high {g,f,e,d,c,b,a} patterns for digits 0..9.
    localparam logic [6:0] SEG_DIGITS [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    function automatic logic [6:0] seg7(input logic [3:0] d);
        return (d <= 4'd9) ? SEG_DIGITS[d] : 7'h00;
    endfunction

endpackage

// File: rtl/alu_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle.
// Ports: clk, ar (sync reset), i_start/i_bin load a value; o_done is high in
// the cycle whose edge performs the final shift, o_bcd is the BCD value that
// edge produces (so a consumer can capture the finished result on o_done).
module alu_bin2bcd #(
    parameter int WIDTH = 16,
    parameter int ND    = 5
) (
    input  logic              clk,
    input  logic              ar,
    input  logic              i_start,
    input  logic [WIDTH-1:0]  i_bin,
    output logic              o_done,
    output logic [4*ND-1:0]   o_bcd
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_sh;
    logic [4*ND-1:0]  r_bcd;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;

    // One double-dabble step: add 3 to every digit >= 5, then shift in b.
    function automatic logic [4*ND-1:0] dabble(
        input logic [4*ND-1:0] d,
        input logic            b
    );
        logic [4*ND-1:0] t;
        t = d;
        for (int i = 0; i < ND; i++) begin
            if (d[4*i +: 4] >= 4'd5) begin
                t[4*i +: 4] = d[4*i +: 4] + 4'd3;
            end
        end
        return {t[4*ND-2:0], b};
    endfunction

    assign o_bcd  = dabble(r_bcd, r_sh[WIDTH-1]);
    assign o_done = r_busy && (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (ar) begin
            r_sh   <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_sh   <= i_bin;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_bcd <= o_bcd;
            r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt + CW'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq_bcd.sv
// Sequential signed ALU (add/sub/shift-add multiply/negate) with BCD and
// seven-segment display outputs. Ports: clk, ar (sync reset), start, a, b,
// mode in; busy, done, result, sign, bcd, seg out.
module alu_seq_bcd
    import alu_pkg::*;
#(
    parameter int W  = 8,
    parameter int ND = 5
) (
    input  logic             clk,
    input  logic             ar,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   result,
    output logic             sign,
    output logic [4*ND-1:0]  bcd,
    output logic [7*ND-1:0]  seg
);

    localparam int CW = $clog2(W);
    localparam int SW = 7 * ND;
    localparam logic [SW-1:0] SEG_RST = SW'(SEG_DIGITS[0]);

    state_e r_state;
    state_e w_state_nxt;

    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    mode_e           r_mode;
    logic [2*W-1:0]  r_acc;
    logic [2*W-1:0]  r_mcand;
    logic [W-1:0]    r_mplier;
    logic            r_neg;
    logic [CW-1:0]   r_cnt;
    logic [2*W-1:0]  r_calc;

    logic [2*W-1:0]  r_result;
    logic            r_sign;
    logic [4*ND-1:0] r_bcd;
    logic [SW-1:0]   r_seg;

    logic            w_accept;
    logic            w_calc_last;
    logic            w_conv_start;
    logic            w_conv_done;
    logic [2*W-1:0]  w_ae;
    logic [2*W-1:0]  w_be;
    logic [2*W-1:0]  w_acc_nxt;
    logic [2*W-1:0]  w_res;
    logic [2*W-1:0]  w_mag;
    logic [4*ND-1:0] w_bcd_fin;

    function automatic logic [W-1:0] mag_w(input logic [W-1:0] x);
        return x[W-1] ? -x : x;
    endfunction

    // Blank every digit above the most significant nonzero one;
    // digit 0 is always lit.
    function automatic logic [SW-1:0] seg_map(input logic [4*ND-1:0] d);
        logic [SW-1:0] s;
        logic          lit;
        s   = '0;
        lit = 1'b0;
        for (int i = ND - 1; i >= 0; i--) begin
            if (d[4*i +: 4] != 4'd0 || i == 0) begin
                lit = 1'b1;
            end
            if (lit) begin
                s[7*i +: 7] = seg7(d[4*i +: 4]);
            end
        end
        return s;
    endfunction

    assign w_accept     = (r_state == ST_IDLE) && start;
    assign w_calc_last  = (r_mode != MODE_MUL) || (r_cnt == CW'(W - 1));
    assign w_conv_start = (r_state == ST_CALC) && w_calc_last;

    assign w_ae      = {{W{r_a[W-1]}}, r_a};
    assign w_be      = {{W{r_b[W-1]}}, r_b};
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_res = '0;
        unique case (r_mode)
            MODE_ADD: w_res = w_ae + w_be;
            MODE_SUB: w_res = w_ae - w_be;
            // Zero product stays positive so there is no negative zero.
            MODE_MUL: w_res = (r_neg && w_acc_nxt != '0) ? -w_acc_nxt
                                                         : w_acc_nxt;
            MODE_NEG: w_res = -w_ae;
            default:  w_res = '0;
        endcase
    end

    assign w_mag = w_res[2*W-1] ? -w_res : w_res;

    alu_bin2bcd #(
        .WIDTH (2 * W),
        .ND    (ND)
    ) u_bin2bcd (
        .clk     (clk),
        .ar      (ar),
        .i_start (w_conv_start),
        .i_bin   (w_mag),
        .o_done  (w_conv_done),
        .o_bcd   (w_bcd_fin)
    );

    always_ff @(posedge clk) begin
        if (ar) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (start)       w_state_nxt = ST_CALC;
            ST_CALC: if (w_calc_last) w_state_nxt = ST_CONV;
            ST_CONV: if (w_conv_done) w_state_nxt = ST_DONE;
            ST_DONE:                  w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ar) begin
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= MODE_ADD;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_calc   <= '0;
            r_result <= '0;
            r_sign   <= 1'b0;
            r_bcd    <= '0;
            r_seg    <= SEG_RST;
        end else begin
            if (w_accept) begin
                r_a      <= a;
                r_b      <= b;
                r_mode   <= mode_e'(mode);
                r_acc    <= '0;
                r_mcand  <= {{W{1'b0}}, mag_w(a)};
                r_mplier <= mag_w(b);
                r_neg    <= a[W-1] ^ b[W-1];
                r_cnt    <= '0;
            end
            if (r_state == ST_CALC) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= {r_mcand[2*W-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[W-1:1]};
                r_cnt    <= r_cnt + CW'(1);
                if (w_calc_last) begin
                    r_calc <= w_res;
                end
            end
            if (w_conv_done) begin
                r_result <= r_calc;
                r_sign   <= r_calc[2*W-1];
                r_bcd    <= w_bcd_fin;
                r_seg    <= seg_map(w_bcd_fin);
            end
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);
    assign result = r_result;
    assign sign   = r_sign;
    assign bcd    = r_bcd;
    assign seg    = r_seg;

endmodule

// File: tb/tb_alu_seq_bcd.sv
// Scoreboard bench for alu_seq_bcd (W=8, ND=5): directed cases, reset abort,
// and randomized traffic with start held high across busy periods.
module tb_alu_seq_bcd;

    localparam int W  = 8;
    localparam int ND = 5;

    localparam logic [6:0] SEGTAB [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    typedef struct {
        logic [2*W-1:0]  res;
        logic            sgn;
        logic [4*ND-1:0] bcd;
        logic [7*ND-1:0] seg;
        int              edge_n;
    } exp_t;

    logic             clk;
    logic             ar;
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [1:0]       mode;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   result;
    logic             sign;
    logic [4*ND-1:0]  bcd;
    logic [7*ND-1:0]  seg;

    exp_t sb[$];
    int   cyc;
    int   free_at;
    int   n_cmp;
    int   n_fail;

    alu_seq_bcd #(.W(W), .ND(ND)) dut (
        .clk    (clk),
        .ar     (ar),
        .start  (start),
        .a      (a),
        .b      (b),
        .mode   (mode),
        .busy   (busy),
        .done   (done),
        .result (result),
        .sign   (sign),
        .bcd    (bcd),
        .seg    (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic, decimal digits by division.
    function automatic exp_t model(
        input logic [W-1:0] aa,
        input logic [W-1:0] bb,
        input logic [1:0]   md,
        input int           acc_edge
    );
        exp_t       e;
        int         x;
        int         y;
        int         r;
        int         m;
        int         top;
        logic [3:0] dg [ND];
        x = $signed(aa);
        y = $signed(bb);
        case (md)
            2'd0:    r = x + y;
            2'd1:    r = x - y;
            2'd2:    r = x * y;
            default: r = -x;
        endcase
        e.res = (2*W)'(r);
        e.sgn = (r < 0);
        m     = (r < 0) ? -r : r;
        e.bcd = '0;
        e.seg = '0;
        top   = 0;
        for (int i = 0; i < ND; i++) begin
            dg[i] = 4'(m % 10);
            m     = m / 10;
            e.bcd[4*i +: 4] = dg[i];
            if (dg[i] != 4'd0) top = i;
        end
        for (int i = 0; i <= top; i++) begin
            e.seg[7*i +: 7] = SEGTAB[dg[i]];
        end
        e.edge_n = acc_edge + ((md == 2'd2) ? W : 1) + 2*W;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'h00;
            3:       return 8'hFF;
            default: return W'($urandom);
        endcase
    endfunction

    // One cycle of stimulus; the model decides whether start is accepted.
    task automatic cyc_op(input logic st, input logic [W-1:0] aa,
                          input logic [W-1:0] bb, input logic [1:0] md);
        @(posedge clk);
        #1;
        chk("busy", 64'(busy), 64'(cyc < free_at));
        start = st;
        a     = aa;
        b     = bb;
        mode  = md;
        if (st && cyc >= free_at) begin
            sb.push_back(model(aa, bb, md, cyc + 1));
            free_at = cyc + 1 + ((md == 2'd2) ? W : 1) + 2*W + 1;
        end
    endtask

    task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic [1:0] md);
        int k;
        cyc_op(1'b1, aa, bb, md);
        k = 0;
        while (cyc < free_at && k < 64) begin
            cyc_op(1'b0, W'($urandom), W'($urandom), 2'($urandom));
            k++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        ar    = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        ar = 1'b0;
        sb.delete();
        free_at = 0;
        chk("rst_busy",   64'(busy),   64'(0));
        chk("rst_done",   64'(done),   64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_sign",   64'(sign),   64'(0));
        chk("rst_bcd",    64'(bcd),    64'(0));
        chk("rst_seg",    64'(seg),    64'(SEGTAB[0]));
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL done_unexpected: actual=1 required=0 (cycle %0d)",
                         cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", 64'(cyc),    64'(e.edge_n));
                chk("result",     64'(result), 64'(e.res));
                chk("sign",       64'(sign),   64'(e.sgn));
                chk("bcd",        64'(bcd),    64'(e.bcd));
                chk("seg",        64'(seg),    64'(e.seg));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        n_cmp   = 0;
        n_fail  = 0;
        free_at = 0;
        ar      = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        mode    = 2'd0;
        do_reset();

        run_op(8'd100, 8'd27, 2'd0);
        run_op(8'h80,  8'h7F, 2'd1);
        run_op(8'h80,  8'h80, 2'd2);
        run_op(8'hF9,  8'h00, 2'd2);
        run_op(8'h80,  8'h00, 2'd3);
        run_op(8'h05,  8'h00, 2'd3);
        run_op(8'h7F,  8'h80, 2'd2);
        run_op(8'hFF,  8'h01, 2'd0);

        // Reset in the middle of a multiply: no done, clean restart.
        cyc_op(1'b1, 8'h80, 8'h80, 2'd2);
        repeat (9) cyc_op(1'b0, W'($urandom), W'($urandom), 2'd2);
        do_reset();
        repeat (30) cyc_op(1'b0, W'($urandom), W'($urandom), 2'($urandom));
        run_op(8'd100, 8'd27, 2'd0);

        // start held high with operands changing every cycle.
        for (int i = 0; i < 200; i++) begin
            cyc_op(1'b1, pick(), pick(), 2'($urandom));
        end
        for (int i = 0; i < 1500; i++) begin
            cyc_op($urandom_range(0, 3) != 0, pick(), pick(), 2'($urandom));
        end

        k = 0;
        while (sb.size() != 0 && k < 100) begin
            cyc_op(1'b0, W'($urandom), W'($urandom), 2'($urandom));
            k++;
        end
        chk("drain_pending", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
